// File: rtl/unified_mem_responder_if.sv
// Cache-side bus of the unified memory responder: one instruction block-read
// port and one data block-read/write port, each with its own busywait stall.
interface unified_mem_responder_if;
    logic         INSTRUCT_MEM_READENABLE;
    logic [5:0]   INSTRUCT_MEM_ADDRESS;
    logic [127:0] INSTRUCT_MEM_READDATA;
    logic         INSTRUCT_MEM_BUSYWAIT;

    logic         READENABLE_MEM;
    logic         WRITEENABLE_MEM;
    logic [5:0]   MEM_ADDRESS;
    logic [31:0]  MEM_WRITEDATA;
    logic [31:0]  MEM_READDATA;
    logic         MEM_BUSYWAIT;

    modport master (
        output INSTRUCT_MEM_READENABLE, INSTRUCT_MEM_ADDRESS,
        input  INSTRUCT_MEM_READDATA, INSTRUCT_MEM_BUSYWAIT,
        output READENABLE_MEM, WRITEENABLE_MEM, MEM_ADDRESS, MEM_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT
    );

    modport slave (
        input  INSTRUCT_MEM_READENABLE, INSTRUCT_MEM_ADDRESS,
        output INSTRUCT_MEM_READDATA, INSTRUCT_MEM_BUSYWAIT,
        input  READENABLE_MEM, WRITEENABLE_MEM, MEM_ADDRESS, MEM_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT
    );
endinterface

// File: rtl/unified_mem_responder.sv
// Single-FSM memory responder serving an instruction port (16-byte blocks) and a data port
// (4-byte blocks) one transaction at a time. Define RESPONDER_ROUND_ROBIN_EN for round-robin arbitration.
module unified_mem_responder #(
    parameter int LATENCY = 4
) (
    input logic                     CLK,
    input logic                     RESET,
    unified_mem_responder_if.slave  mem
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]   state;
    logic [3:0]   count;
    logic         grant_d;
    logic         grant_write;
    logic [5:0]   addr_q;
    logic [31:0]  wdata_q;
    logic [127:0] irdata;
    logic [31:0]  drdata;

    logic [7:0]   imem [0:1023];
    logic [7:0]   dmem [0:255];

    logic         i_req;
    logic         d_req;
    logic         pick_d;
    logic         serving;
    logic         granted_req;
    logic         finish;
    logic [127:0] iblock;
    logic [31:0]  dblock;

    assign i_req       = mem.INSTRUCT_MEM_READENABLE;
    assign d_req       = mem.READENABLE_MEM | mem.WRITEENABLE_MEM;
    assign serving     = (state == SERVE_I) || (state == SERVE_D);
    assign granted_req = (state == SERVE_D) ? d_req : i_req;
    assign finish      = serving && granted_req && (count == 4'd0);

`ifdef RESPONDER_ROUND_ROBIN_EN
    // last_d remembers who won the previous grant; reset favours the instruction port
    logic last_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_d <= 1'b1;
        end else if ((state == IDLE) && (i_req || d_req)) begin
            last_d <= pick_d;
        end
    end

    assign pick_d = d_req & (~i_req | ~last_d);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            count       <= 4'd0;
            grant_d     <= 1'b0;
            grant_write <= 1'b0;
            addr_q      <= 6'd0;
            wdata_q     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state       <= pick_d ? SERVE_D : SERVE_I;
                        count       <= COUNT_LOAD;
                        grant_d     <= pick_d;
                        grant_write <= pick_d & mem.WRITEENABLE_MEM;
                        addr_q      <= pick_d ? mem.MEM_ADDRESS : mem.INSTRUCT_MEM_ADDRESS;
                        wdata_q     <= mem.MEM_WRITEDATA;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // a withdrawn request wins over completion so nothing is committed
                    if (!granted_req) begin
                        state <= IDLE;
                    end else if (count == 4'd0) begin
                        state <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        iblock = '0;
        dblock = '0;
        for (int b = 0; b < 16; b++) begin
            iblock[8*b +: 8] = imem[{addr_q, 4'(b)}];
        end
        for (int b = 0; b < 4; b++) begin
            dblock[8*b +: 8] = dmem[{addr_q, 2'(b)}];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            irdata <= '0;
            drdata <= '0;
        end else if (finish && !grant_write) begin
            if (state == SERVE_D) begin
                drdata <= dblock;
            end else begin
                irdata <= iblock;
            end
        end
    end

    // Array contents survive reset, so the write port has no reset branch
    always_ff @(posedge CLK) begin
        if (finish && grant_write) begin
            for (int b = 0; b < 4; b++) begin
                dmem[{addr_q, 2'(b)}] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign mem.INSTRUCT_MEM_READDATA = irdata;
    assign mem.MEM_READDATA          = drdata;

    assign mem.INSTRUCT_MEM_BUSYWAIT = RESET & i_req & ~((state == DONE) & ~grant_d);
    assign mem.MEM_BUSYWAIT          = RESET & d_req & ~((state == DONE) & grant_d);

endmodule

// File: tb/tb_unified_mem_responder.sv
// Randomized bench for unified_mem_responder: a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations (RESPONDER_ROUND_ROBIN_EN selects arbitration).
module tb_unified_mem_responder;
    localparam int LAT = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   total = 0;
    int   passed = 0;
    bit   check_en = 1'b0;

    unified_mem_responder_if bus ();
    unified_mem_responder_if bus2 ();

    unified_mem_responder #(.LATENCY(LAT)) dut (.CLK(CLK), .RESET(RESET), .mem(bus));
    unified_mem_responder #(.LATENCY(2)) dut2 (.CLK(CLK), .RESET(RESET), .mem(bus2));

    always #5 CLK = ~CLK;

    logic [7:0]   ref_imem [1024];
    logic [7:0]   ref_dmem [256];
    bit           m_in = 1'b0;
    bit           m_port_d = 1'b0;
    bit           m_write = 1'b0;
    bit           m_last_d = 1'b1;
    int           m_edges = 0;
    int           m_addr = 0;
    logic [31:0]  m_wdata = '0;
    logic [127:0] exp_irdata = '0;
    logic [31:0]  exp_drdata = '0;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Transaction-level reference: m_edges counts rising edges since the grant (grant edge = 1);
    // the transaction completes when it reaches LAT+1 and the port is released one edge later.
    always @(posedge CLK or negedge RESET) begin
        bit ireq, dreq, pick_d;
        if (!RESET) begin
            m_in = 1'b0;
            m_edges = 0;
            m_last_d = 1'b1;
            exp_irdata = '0;
            exp_drdata = '0;
        end else begin
            ireq = bus.INSTRUCT_MEM_READENABLE;
            dreq = bus.READENABLE_MEM || bus.WRITEENABLE_MEM;
            if (m_in) begin
                if (m_edges == LAT + 1) m_in = 1'b0;
                else if (!(m_port_d ? dreq : ireq)) m_in = 1'b0;
                else begin
                    m_edges++;
                    if (m_edges == LAT + 1) begin
                        if (m_port_d && m_write)
                            for (int b = 0; b < 4; b++) ref_dmem[m_addr*4 + b] = m_wdata[8*b +: 8];
                        else if (m_port_d)
                            for (int b = 0; b < 4; b++) exp_drdata[8*b +: 8] = ref_dmem[m_addr*4 + b];
                        else
                            for (int b = 0; b < 16; b++) exp_irdata[8*b +: 8] = ref_imem[m_addr*16 + b];
                    end
                end
            end else if (ireq || dreq) begin
`ifdef RESPONDER_ROUND_ROBIN_EN
                pick_d = dreq && (!ireq || !m_last_d);
`else
                pick_d = dreq;
`endif
                m_last_d = pick_d;
                m_in = 1'b1;
                m_edges = 1;
                m_port_d = pick_d;
                m_write = pick_d && bus.WRITEENABLE_MEM;
                m_addr = pick_d ? int'(bus.MEM_ADDRESS) : int'(bus.INSTRUCT_MEM_ADDRESS);
                m_wdata = bus.MEM_WRITEDATA;
            end
        end
    end

    always @(negedge CLK) begin
        bit exp_ib, exp_db;
        if (check_en) begin
            exp_ib = RESET && bus.INSTRUCT_MEM_READENABLE && !(m_in && !m_port_d && m_edges == LAT + 1);
            exp_db = RESET && (bus.READENABLE_MEM || bus.WRITEENABLE_MEM)
                     && !(m_in && m_port_d && m_edges == LAT + 1);
            checkOutput("i_busywait", 128'(bus.INSTRUCT_MEM_BUSYWAIT), 128'(exp_ib));
            checkOutput("d_busywait", 128'(bus.MEM_BUSYWAIT), 128'(exp_db));
            checkOutput("i_readdata", bus.INSTRUCT_MEM_READDATA, exp_irdata);
            checkOutput("d_readdata", 128'(bus.MEM_READDATA), 128'(exp_drdata));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts cycles with the chosen port stalled; returns at the negedge of its first free cycle
    task automatic waitDone(input bit on_i, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK);
            if (!(on_i ? bus.INSTRUCT_MEM_BUSYWAIT : bus.MEM_BUSYWAIT)) seen = 1'b1;
            else cycles++;
        end
    endtask

    task automatic writeData(input logic [5:0] addr, input logic [31:0] data, input string name);
        int cyc;
        bus.WRITEENABLE_MEM = 1'b1;
        bus.MEM_ADDRESS = addr;
        bus.MEM_WRITEDATA = data;
        waitDone(1'b0, cyc);
        checkOutput({name, "_stall"}, 128'(cyc), 128'(5));
        tick();
        bus.WRITEENABLE_MEM = 1'b0;
    endtask

    task automatic readData(input logic [5:0] addr, input logic [31:0] expected, input string name);
        int cyc;
        bus.READENABLE_MEM = 1'b1;
        bus.MEM_ADDRESS = addr;
        waitDone(1'b0, cyc);
        checkOutput({name, "_stall"}, 128'(cyc), 128'(5));
        checkOutput(name, 128'(bus.MEM_READDATA), 128'(expected));
        tick();
        bus.READENABLE_MEM = 1'b0;
    endtask

    task automatic runDut2Read(input logic [5:0] addr, input logic [127:0] expected, input string name);
        int e = 0;
        bit seen = 1'b0;
        bus2.INSTRUCT_MEM_ADDRESS = addr;
        bus2.INSTRUCT_MEM_READENABLE = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge CLK);
            e++;
            @(negedge CLK);
            if (!bus2.INSTRUCT_MEM_BUSYWAIT) seen = 1'b1;
        end
        checkOutput({name, "_edges"}, 128'(e), 128'(3));
        checkOutput(name, bus2.INSTRUCT_MEM_READDATA, expected);
        tick();
    endtask

    // Cache-like random agents: hold requests until served, sometimes re-issue, abort or wiggle address/data
    task automatic applyStimulus(input int cycles);
        bit i_fin, d_fin;
        int kind;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLK);
            i_fin = bus.INSTRUCT_MEM_READENABLE && !bus.INSTRUCT_MEM_BUSYWAIT;
            d_fin = (bus.READENABLE_MEM || bus.WRITEENABLE_MEM) && !bus.MEM_BUSYWAIT;
            tick();
            if (bus.INSTRUCT_MEM_READENABLE) begin
                if (i_fin) begin
                    if ($urandom_range(0, 3) == 0) bus.INSTRUCT_MEM_ADDRESS = 6'($urandom_range(0, 63));
                    else bus.INSTRUCT_MEM_READENABLE = 1'b0;
                end else if ($urandom_range(0, 49) == 0) bus.INSTRUCT_MEM_READENABLE = 1'b0;
                else if ($urandom_range(0, 3) == 0) bus.INSTRUCT_MEM_ADDRESS = 6'($urandom_range(0, 63));
            end else if ($urandom_range(0, 2) == 0) begin
                bus.INSTRUCT_MEM_READENABLE = 1'b1;
                bus.INSTRUCT_MEM_ADDRESS = 6'($urandom_range(0, 63));
            end
            if (bus.READENABLE_MEM || bus.WRITEENABLE_MEM) begin
                if (d_fin || $urandom_range(0, 49) == 0) begin
                    bus.READENABLE_MEM = 1'b0;
                    bus.WRITEENABLE_MEM = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.MEM_ADDRESS = 6'($urandom_range(0, 63));
                    bus.MEM_WRITEDATA = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                kind = $urandom_range(0, 3);
                bus.READENABLE_MEM = (kind != 2);
                bus.WRITEENABLE_MEM = (kind >= 2);
                bus.MEM_ADDRESS = 6'($urandom_range(0, 63));
                bus.MEM_WRITEDATA = $urandom;
            end
        end
        tick();
        bus.INSTRUCT_MEM_READENABLE = 1'b0;
        bus.READENABLE_MEM = 1'b0;
        bus.WRITEENABLE_MEM = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int de, ie, e, cyc;

        bus.INSTRUCT_MEM_READENABLE = 1'b0;
        bus.INSTRUCT_MEM_ADDRESS = '0;
        bus.READENABLE_MEM = 1'b0;
        bus.WRITEENABLE_MEM = 1'b0;
        bus.MEM_ADDRESS = '0;
        bus.MEM_WRITEDATA = '0;
        bus2.INSTRUCT_MEM_READENABLE = 1'b0;
        bus2.INSTRUCT_MEM_ADDRESS = '0;
        bus2.READENABLE_MEM = 1'b0;
        bus2.WRITEENABLE_MEM = 1'b0;
        bus2.MEM_ADDRESS = '0;
        bus2.MEM_WRITEDATA = '0;

        // Instruction bytes 0..63 equal their own address, the rest are random
        for (int i = 0; i < 1024; i++) begin
            v = (i < 64) ? 8'(i) : 8'($urandom_range(0, 255));
            dut.imem[i] = v;
            dut2.imem[i] = v;
            ref_imem[i] = v;
        end
        for (int i = 0; i < 256; i++) ref_dmem[i] = '0;

        #2 RESET = 1'b0;
        check_en = 1'b1;
        @(negedge CLK);
        checkOutput("reset_i_readdata", bus.INSTRUCT_MEM_READDATA, 128'h0);
        checkOutput("reset_d_readdata", 128'(bus.MEM_READDATA), 128'h0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;

        $display("[TB] preloading data memory through the write port");
        for (int b = 0; b < 64; b++)
            writeData(6'(b), {8'(4*b + 3), 8'(4*b + 2), 8'(4*b + 1), 8'(4*b)}, "init_write");

        $display("[TB] write/read block 5");
        writeData(6'd5, 32'hDDCCBBAA, "w5");
        readData(6'd5, 32'hDDCCBBAA, "r5");

        $display("[TB] aborted write to block 3");
        bus.WRITEENABLE_MEM = 1'b1;
        bus.MEM_ADDRESS = 6'd3;
        bus.MEM_WRITEDATA = 32'h12345678;
        tick();
        bus.MEM_ADDRESS = 6'd9;
        tick();
        bus.WRITEENABLE_MEM = 1'b0;
        tick();
        readData(6'd3, 32'h0F0E0D0C, "abort_r3");

        $display("[TB] reset during write to block 7");
        bus.WRITEENABLE_MEM = 1'b1;
        bus.MEM_ADDRESS = 6'd7;
        bus.MEM_WRITEDATA = 32'hCAFEF00D;
        bus.INSTRUCT_MEM_READENABLE = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        checkOutput("rst_d_busy", 128'(bus.MEM_BUSYWAIT), 128'h0);
        checkOutput("rst_i_busy", 128'(bus.INSTRUCT_MEM_BUSYWAIT), 128'h0);
        checkOutput("rst_d_readdata", 128'(bus.MEM_READDATA), 128'h0);
        tick();
        bus.WRITEENABLE_MEM = 1'b0;
        bus.INSTRUCT_MEM_READENABLE = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        readData(6'd7, 32'h1F1E1D1C, "rst_r7");
        readData(6'd5, 32'hDDCCBBAA, "rst_r5");

        $display("[TB] simultaneous instruction and data reads");
        bus.INSTRUCT_MEM_READENABLE = 1'b1;
        bus.INSTRUCT_MEM_ADDRESS = 6'd0;
        bus.READENABLE_MEM = 1'b1;
        bus.MEM_ADDRESS = 6'd1;
        e = 0; de = 0; ie = 0;
        for (int k = 0; k < 30 && (de == 0 || ie == 0); k++) begin
            @(posedge CLK);
            e++;
            #1;
            if (de != 0) bus.READENABLE_MEM = 1'b0;
            if (ie != 0) bus.INSTRUCT_MEM_READENABLE = 1'b0;
            @(negedge CLK);
            if (de == 0 && !bus.MEM_BUSYWAIT) begin
                de = e;
                checkOutput("sim_d_readdata", 128'(bus.MEM_READDATA), 128'h07060504);
            end
            if (ie == 0 && !bus.INSTRUCT_MEM_BUSYWAIT) begin
                ie = e;
                checkOutput("sim_i_readdata", bus.INSTRUCT_MEM_READDATA, 128'h0F0E0D0C0B0A09080706050403020100);
            end
        end
`ifdef RESPONDER_ROUND_ROBIN_EN
        checkOutput("sim_i_done_edge", 128'(ie), 128'(5));
        checkOutput("sim_d_done_edge", 128'(de), 128'(11));
`else
        checkOutput("sim_d_done_edge", 128'(de), 128'(5));
        checkOutput("sim_i_done_edge", 128'(ie), 128'(11));
`endif
        tick();
        bus.READENABLE_MEM = 1'b0;
        bus.INSTRUCT_MEM_READENABLE = 1'b0;
        tick();

        $display("[TB] instruction read of block 2");
        bus.INSTRUCT_MEM_READENABLE = 1'b1;
        bus.INSTRUCT_MEM_ADDRESS = 6'd2;
        waitDone(1'b1, cyc);
        checkOutput("i2_stall", 128'(cyc), 128'(5));
        checkOutput("i2_readdata", bus.INSTRUCT_MEM_READDATA, 128'h2F2E2D2C2B2A29282726252423222120);
        tick();
        bus.INSTRUCT_MEM_READENABLE = 1'b0;

        $display("[TB] back-to-back reads with LATENCY=2");
        runDut2Read(6'd0, 128'h0F0E0D0C0B0A09080706050403020100, "lat2_b0");
        runDut2Read(6'd1, 128'h1F1E1D1C1B1A19181716151413121110, "lat2_b1");
        bus2.INSTRUCT_MEM_READENABLE = 1'b0;

        $display("[TB] randomized traffic");
        applyStimulus(3000);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/unified_mem_responder.md
UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from grant to response (legal 2..15).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous active-low reset.
REQ-004 SHALL have port INSTRUCT_MEM_READENABLE  input  1  instruction-cache block read request.
REQ-005 SHALL have port INSTRUCT_MEM_ADDRESS  input  6  instruction block address (16-byte blocks).
REQ-006 SHALL have port INSTRUCT_MEM_READDATA  output  128  instruction block data, byte 0 in bits [7:0].
REQ-007 SHALL have port INSTRUCT_MEM_BUSYWAIT  output  1  instruction port stall.
REQ-008 SHALL have port READENABLE_MEM  input  1  data-cache block read request.
REQ-009 SHALL have port WRITEENABLE_MEM  input  1  data-cache block write request.
REQ-010 SHALL have port MEM_ADDRESS  input  6  data block address (4-byte blocks).
REQ-011 SHALL have port MEM_WRITEDATA  input  32  data block to write, byte 0 in bits [7:0].
REQ-012 SHALL have port MEM_READDATA  output  32  data block read result.
REQ-013 SHALL have port MEM_BUSYWAIT  output  1  data port stall.

Function
REQ-014 SHALL hold two byte arrays: instruction 1024 bytes, data 256 bytes; byte address = {block address, offset}.
REQ-015 SHALL serve one transaction at a time through a single FSM: IDLE, SERVE_I, SERVE_D, DONE.
REQ-016 SHALL, in IDLE with a request present at a rising edge, grant it, load the down-counter with LATENCY-1, and enter SERVE_I or SERVE_D.
REQ-017 SHALL decrement the counter each cycle in SERVE_x and enter DONE on the edge where the counter equals 0.
REQ-018 SHALL drive each BUSYWAIT combinationally high whenever that port's request is asserted, except in DONE for the granted port.
REQ-019 SHALL, therefore, assert BUSYWAIT in the same cycle a request rises, with no idle gap.
REQ-020 SHALL, on entering DONE for a read, register the full block onto the granted READDATA, and hold it until the next read completion on that port.
REQ-021 SHALL, on entering DONE for a data write, commit all 4 bytes of MEM_WRITEDATA in one edge.
REQ-022 SHALL leave DONE after exactly one cycle to IDLE; a request still asserted in IDLE is a new transaction.
REQ-023 SHALL abort with no write and return to IDLE if the granted request deasserts during SERVE_x.
REQ-024 SHALL treat READENABLE_MEM and WRITEENABLE_MEM both high as a write.
REQ-025 SHALL sample address and write data at grant and ignore later changes until DONE.
REQ-026 SHALL keep the non-granted port stalled (BUSYWAIT high) until it is granted.
REQ-027 SHALL grant the data port on simultaneous requests in IDLE, unless REQ-032 applies.
REQ-028 SHALL give end-to-end latency of LATENCY+1 rising edges from request to BUSYWAIT low (grant edge + LATENCY).

Reset
REQ-029 SHALL, on RESET low, immediately force FSM to IDLE, counter to 0, both READDATA to 0, and abort any transaction without writing.
REQ-030 SHALL drive BUSYWAIT low during reset regardless of requests.
REQ-031 SHALL NOT alter array contents on reset.

Configuration
REQ-032 SHALL, with RESPONDER_ROUND_ROBIN_EN defined, grant simultaneous requests to the port not served last (initial: instruction port first after reset); without it, grant the data port per REQ-027.

Verification
REQ-033 Data write 0xDDCCBBAA to MEM_ADDRESS 5, then read 5 -> MEM_BUSYWAIT high 5 cycles each, MEM_READDATA = 0xDDCCBBAA in DONE.
REQ-034 Instruction read block 2 preloaded with bytes 0x20..0x2F -> INSTRUCT_MEM_READDATA = 0x2F2E...2120 after 5 cycles.
REQ-035 Simultaneous I read of block 0 and D read of block 1 -> data served first (done at edge 5), instruction done at edge 11; with RESPONDER_ROUND_ROBIN_EN, instruction first.
REQ-036 WRITEENABLE_MEM dropped after 2 cycles of a write to block 3 -> FSM returns IDLE, block 3 unchanged.
REQ-037 RESET low during SERVE_D of a write to block 7 -> BUSYWAIT low, READDATA 0, block 7 unchanged, prior blocks intact.
REQ-038 LATENCY=2, back-to-back reads of blocks 0 and 1 -> each completes 3 edges after issue, no lost request.
